// File: rtl/ysyx_24110006_lsu_pkg.sv
// ysyx_24110006_lsu_pkg: FSM states, load funct3 codes, mcause values, AXI response code and a misalignment helper shared by the LSU files.
package ysyx_24110006_lsu_pkg;
   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR, S_WR_B, S_DONE} lsu_state_t;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [3:0] MCAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] MCAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] MCAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] MCAUSE_ST_FAULT    = 4'd7;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   // Access size comes from funct3 for loads and from the unshifted mask for stores; loads win when both are set.
   function automatic logic misaligned(input logic ren, input logic wen, input logic [2:0] rt, input logic [3:0] wmask, input logic [1:0] lo);
      logic half, word;
      half = ren ? (rt[1:0] == F3_LH[1:0]) : (wmask == 4'b0011);
      word = ren ? (rt[1:0] == F3_LW[1:0]) : (wmask == 4'b1111);
      return (ren || wen) && ((half && lo[0]) || (word && lo != 2'b00));
   endfunction
endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// ysyx_24110006_lsu_align: store lane shift/strobe generation and load byte extraction with sign/zero extension.
// Ports: lo (address bits [1:0]), st_in/mask_in (unshifted store data/mask), read_t (load funct3), rdata (bus word);
//        st_data/st_strb (lane-shifted store data and strobe), ld_data (extended load result).
module ysyx_24110006_lsu_align
   import ysyx_24110006_lsu_pkg::*;
(
   input  logic [1:0]  lo,
   input  logic [31:0] st_in,
   input  logic [3:0]  mask_in,
   input  logic [2:0]  read_t,
   input  logic [31:0] rdata,
   output logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic [31:0] ld_data
);
   logic [31:0] d;
   // Lanes shifted past byte 3 fall off the top and are silently dropped.
   assign st_data = st_in << {lo, 3'b000};
   assign st_strb = mask_in << lo;
   assign d = rdata >> {lo, 3'b000};
   always_comb begin
      ld_data = d;
      case (read_t)
         F3_LB:   ld_data = {{24{d[7]}}, d[7:0]};
         F3_LH:   ld_data = {{16{d[15]}}, d[15:0]};
         F3_LW:   ld_data = d;
         F3_LBU:  ld_data = {24'h0, d[7:0]};
         F3_LHU:  ld_data = {16'h0, d[15:0]};
         default: ld_data = d;
      endcase
   end
endmodule

// File: rtl/ysyx_24110006_lsu.sv
// ysyx_24110006_lsu: load/store unit bridging the EXU request handshake to an AXI4-Lite master and handing results to the WBU.
// Ports: i_clock, i_reset (sync, active-low); EXU side i_valid/o_ready with i_mem_* request, i_result, i_reg_rd, i_reg_wen, i_pc;
//        WBU side o_valid/i_ready with o_result, o_reg_rd, o_reg_wen, o_pc, o_exception, o_mcause;
//        AXI4-Lite master m_ar*, m_r*, m_aw*, m_w*, m_b*.
// Optional: define YSYX_LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses without touching the bus.
module ysyx_24110006_lsu
   import ysyx_24110006_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_mem_ren,
   input  logic              i_mem_wen,
   input  logic [3:0]        i_mem_wmask,
   input  logic [2:0]        i_mem_read_t,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   input  logic [DATA_W-1:0] i_result,
   input  logic [4:0]        i_reg_rd,
   input  logic              i_reg_wen,
   input  logic [31:0]       i_pc,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_result,
   output logic [4:0]        o_reg_rd,
   output logic              o_reg_wen,
   output logic [31:0]       o_pc,
   output logic              o_exception,
   output logic [3:0]        o_mcause,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready
);
   lsu_state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, result_q, ld_data;
   logic [3:0] wmask_q, mcause_q;
   logic [2:0] rt_q;
   logic [4:0] rd_q;
   logic [31:0] pc_q;
   logic wen_q, exc_q, aw_done_q, w_done_q, accept, mis, aw_hs, w_hs;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
   assign mis = misaligned(i_mem_ren, i_mem_wen, i_mem_read_t, i_mem_wmask, i_mem_addr[1:0]);
`else
   assign mis = 1'b0;
`endif
   // DONE accepts alongside the WBU handshake so passthrough ops can stream back-to-back.
   assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE && i_ready);
   assign accept = i_valid && o_ready;
   assign o_valid = state_q == S_DONE;
   assign m_arvalid = state_q == S_RD_A;
   assign m_rready = state_q == S_RD_D;
   assign m_awvalid = state_q == S_WR && !aw_done_q;
   assign m_wvalid = state_q == S_WR && !w_done_q;
   assign m_bready = state_q == S_WR_B;
   assign aw_hs = m_awvalid && m_awready;
   assign w_hs = m_wvalid && m_wready;
   assign m_araddr = {addr_q[ADDR_W-1:2], 2'b00};
   assign m_awaddr = m_araddr;
   assign o_result = result_q;
   assign o_reg_rd = rd_q;
   assign o_reg_wen = wen_q && !exc_q;
   assign o_pc = pc_q;
   assign o_exception = exc_q;
   assign o_mcause = mcause_q;
   ysyx_24110006_lsu_align u_align (
      .lo      (addr_q[1:0]),
      .st_in   (wdata_q),
      .mask_in (wmask_q),
      .read_t  (rt_q),
      .rdata   (m_rdata),
      .st_data (m_wdata),
      .st_strb (m_wstrb),
      .ld_data (ld_data)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = accept ? (mis ? S_DONE : i_mem_ren ? S_RD_A : i_mem_wen ? S_WR : S_DONE)
                                          : (state_q == S_DONE && i_ready) ? S_IDLE : state_q;
         S_RD_A:  state_d = m_arready ? S_RD_D : S_RD_A;
         S_RD_D:  state_d = m_rvalid ? S_DONE : S_RD_D;
         S_WR:    state_d = (aw_done_q || aw_hs) && (w_done_q || w_hs) ? S_WR_B : S_WR;
         S_WR_B:  state_d = m_bvalid ? S_DONE : S_WR_B;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         exc_q <= 1'b0;
         mcause_q <= 4'h0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= i_mem_addr;
            wdata_q <= i_mem_wdata;
            wmask_q <= i_mem_wmask;
            rt_q <= i_mem_read_t;
            result_q <= i_result;
            rd_q <= i_reg_rd;
            wen_q <= i_reg_wen;
            pc_q <= i_pc;
            exc_q <= mis;
            mcause_q <= mis ? (i_mem_ren ? MCAUSE_LD_MISALIGN : MCAUSE_ST_MISALIGN) : 4'h0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
         end
         if (aw_hs) aw_done_q <= 1'b1;
         if (w_hs) w_done_q <= 1'b1;
         if (m_rvalid && m_rready) begin
            result_q <= ld_data;
            exc_q <= m_rresp != RESP_OKAY;
            mcause_q <= (m_rresp != RESP_OKAY) ? MCAUSE_LD_FAULT : 4'h0;
         end
         if (m_bvalid && m_bready) begin
            exc_q <= m_bresp != RESP_OKAY;
            mcause_q <= (m_bresp != RESP_OKAY) ? MCAUSE_ST_FAULT : 4'h0;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// tb_ysyx_24110006_lsu: randomized bench with an AXI slave model and a behavioural LSU reference model.
module tb_ysyx_24110006_lsu;
   logic i_clock = 0, i_reset = 0, i_valid = 0, o_ready;
   logic i_mem_ren = 0, i_mem_wen = 0, i_reg_wen = 0, i_ready = 0;
   logic [3:0] i_mem_wmask = 0;
   logic [2:0] i_mem_read_t = 0;
   logic [31:0] i_mem_addr = 0, i_mem_wdata = 0, i_result = 0, i_pc = 0;
   logic [4:0] i_reg_rd = 0;
   logic o_valid, o_reg_wen, o_exception;
   logic [31:0] o_result, o_pc;
   logic [4:0] o_reg_rd;
   logic [3:0] o_mcause;
   logic [31:0] m_araddr, m_awaddr, m_wdata;
   logic [31:0] m_rdata = 0;
   logic [3:0] m_wstrb;
   logic [1:0] m_rresp = 0, m_bresp = 0;
   logic m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;

   ysyx_24110006_lsu dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask), .i_mem_read_t(i_mem_read_t),
      .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_result(i_result), .i_reg_rd(i_reg_rd),
      .i_reg_wen(i_reg_wen), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_reg_rd(o_reg_rd), .o_reg_wen(o_reg_wen), .o_pc(o_pc), .o_exception(o_exception), .o_mcause(o_mcause),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0, errors = 0;
   // Slave waits: -1 means random wait, otherwise a fixed number of cycles.
   int wt_ar = -1, wt_aw = -1, wt_w = -1, wt_r = -1, wt_b = -1;
   logic use_rd = 0;
   logic [31:0] kr_data = 0;
   logic [1:0] kr_resp = 0;
   logic rdy_rand = 0, rdy_fix = 1;
   // Literal expectations supplied by the directed tests.
   logic l_en = 0, l_wen = 0, l_exc = 0;
   logic [31:0] l_res = 0, l_bus = 0;
   logic [4:0] l_rd = 0;
   logic [3:0] l_mc = 0, l_strb = 0;
   // Reference model of the single in-flight request.
   logic e_act = 0, e_wen = 0, e_exc = 0, e_lit = 0, rst_seen = 0;
   int e_kind = 0, cyc = 0, ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
   logic [31:0] e_addr = 0, e_wd = 0, e_res = 0, e_pc = 0;
   logic [3:0] e_m = 0, e_mc = 0, e_strb;
   logic [2:0] e_rt = 0;
   logic [4:0] e_rd = 0;
   logic e_mis;
   int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
   logic r_pend = 0, aw_ok = 0, w_ok = 0, r_take = 0, b_take = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off, input logic [2:0] rt);
      logic [31:0] d, b, h;
      d = w >> (8 * off);
      b = d & 32'hFF;
      h = d & 32'hFFFF;
      case (rt)
         3'b000:  return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
         3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return d;
      endcase
   endfunction

   function automatic int pick_wait(input int cfg);
      return cfg >= 0 ? cfg : int'($urandom_range(0, 2));
   endfunction

   // i_ready owner, changing 2 time units after the active edge.
   always begin
      @(posedge i_clock);
      #2;
      i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
   end

   // Monitor, model and AXI slave: observe at negedge, drive just after posedge.
   initial forever begin
      @(negedge i_clock);
      cyc++;
      if (rst_seen) begin
         chk("reset_state", {o_ready, o_valid, o_exception, o_mcause, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready},
             {1'b1, 1'b0, 1'b0, 4'h0, 5'b00000});
         rst_seen = 0;
      end
      if (!i_reset) begin
         rst_seen = 1; e_act = 0; r_pend = 0; aw_ok = 0; w_ok = 0; r_take = 0; b_take = 0;
         m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      end else begin
         if (m_arvalid && m_arready) begin
            ar_n++; r_pend = 1; r_wait = pick_wait(wt_r);
            chk("araddr", m_araddr, e_addr & 32'hFFFF_FFFC);
            if (e_lit) chk("lit_araddr", m_araddr, l_bus);
         end
         if (m_rvalid && m_rready) begin
            r_n++; r_pend = 0; r_take = 1;
            e_res = load_val(m_rdata, e_addr[1:0], e_rt);
            e_exc = m_rresp != 2'b00; e_mc = 4'd5;
         end
         if (m_awvalid && m_awready) begin
            aw_n++; aw_ok = 1; b_wait = pick_wait(wt_b);
            chk("awaddr", m_awaddr, e_addr & 32'hFFFF_FFFC);
         end
         if (m_wvalid && m_wready) begin
            w_n++; w_ok = 1;
            e_strb = e_m << e_addr[1:0];
            chk("wdata_strb", {m_wdata, m_wstrb}, {e_wd << (8 * e_addr[1:0]), e_strb});
            if (e_lit) chk("lit_wdata_strb", {m_wdata, m_wstrb}, {l_bus, l_strb});
         end
         if (m_bvalid && m_bready) begin
            b_n++; aw_ok = 0; w_ok = 0; b_take = 1;
            e_exc = m_bresp != 2'b00; e_mc = 4'd7;
         end
         chk("bus_kind", {m_arvalid && !(e_act && e_kind == 1), (m_awvalid || m_wvalid) && !(e_act && e_kind == 2)}, 2'b00);
         if (e_act && (e_kind == 0 || e_kind == 3) && cyc == 1) chk("one_cycle_latency", o_valid, 1'b1);
         if (o_valid) begin
            chk("spurious_valid", o_valid, e_act);
            if (e_act) begin
               chk("done_outputs", {o_result, o_reg_rd, o_reg_wen, o_pc, o_exception, o_exception ? o_mcause : 4'h0},
                   {e_res, e_rd, e_wen && !e_exc, e_pc, e_exc, e_exc ? e_mc : 4'h0});
               chk("bus_counts", {ar_n, r_n, aw_n, w_n, b_n},
                   {(e_kind == 1) ? 1 : 0, (e_kind == 1) ? 1 : 0, (e_kind == 2) ? 1 : 0, (e_kind == 2) ? 1 : 0, (e_kind == 2) ? 1 : 0});
               if (i_ready) begin
                  if (e_lit) chk("lit_done", {o_result, o_reg_rd, o_reg_wen, o_exception, o_exception ? o_mcause : 4'h0},
                                 {l_res, l_rd, l_wen, l_exc, l_exc ? l_mc : 4'h0});
                  e_act = 0;
               end
            end
         end
         if (i_valid && o_ready) begin
            e_mis = 0;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
            if (i_mem_ren) e_mis = (i_mem_read_t[1:0] == 2'b01 && i_mem_addr[0]) || (i_mem_read_t[1:0] == 2'b10 && i_mem_addr[1:0] != 0);
            else if (i_mem_wen) e_mis = (i_mem_wmask == 4'b0011 && i_mem_addr[0]) || (i_mem_wmask == 4'b1111 && i_mem_addr[1:0] != 0);
`endif
            e_kind = e_mis ? 3 : i_mem_ren ? 1 : i_mem_wen ? 2 : 0;
            e_addr = i_mem_addr; e_wd = i_mem_wdata; e_m = i_mem_wmask; e_rt = i_mem_read_t;
            e_res = i_result; e_rd = i_reg_rd; e_wen = i_reg_wen; e_pc = i_pc;
            e_exc = e_mis; e_mc = i_mem_ren ? 4'd4 : 4'd6; e_lit = l_en;
            e_act = 1; cyc = 0; ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
         end
      end
      @(posedge i_clock);
      #1;
      if (i_reset) begin
         if (r_take) begin m_rvalid = 0; r_take = 0; end
         if (b_take) begin m_bvalid = 0; b_take = 0; end
         if (!m_arvalid) begin m_arready = 0; ar_wait = pick_wait(wt_ar); end
         else if (ar_wait > 0) begin m_arready = 0; ar_wait--; end
         else m_arready = 1;
         if (!m_awvalid) begin m_awready = 0; aw_wait = pick_wait(wt_aw); end
         else if (aw_wait > 0) begin m_awready = 0; aw_wait--; end
         else m_awready = 1;
         if (!m_wvalid) begin m_wready = 0; w_wait = pick_wait(wt_w); end
         else if (w_wait > 0) begin m_wready = 0; w_wait--; end
         else m_wready = 1;
         if (r_pend && !m_rvalid) begin
            if (r_wait > 0) r_wait--;
            else begin
               m_rvalid = 1;
               m_rdata = use_rd ? kr_data : $urandom;
               m_rresp = use_rd ? kr_resp : (($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
            end
         end
         if (aw_ok && w_ok && !m_bvalid) begin
            if (b_wait > 0) b_wait--;
            else begin
               m_bvalid = 1;
               m_bresp = use_rd ? kr_resp : (($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
            end
         end
      end
   end

   // Called just after a posedge; returns just after the posedge that accepts the request.
   task automatic req(input logic ren, input logic wen, input logic [3:0] m, input logic [2:0] rt, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] res, input logic [4:0] rd, input logic rwen, input logic [31:0] pc);
      i_valid = 1; i_mem_ren = ren; i_mem_wen = wen; i_mem_wmask = m; i_mem_read_t = rt; i_mem_addr = a;
      i_mem_wdata = wd; i_result = res; i_reg_rd = rd; i_reg_wen = rwen; i_pc = pc;
      for (int t = 0; ; t++) begin
         @(negedge i_clock);
         if (o_ready) break;
         if (t > 300) begin
            $display("FAIL accept_timeout: o_ready stayed low, required 1");
            $fatal(1);
         end
      end
      @(posedge i_clock);
      #1;
      i_valid = 0;
   endtask

   task automatic wait_done();
      for (int t = 0; ; t++) begin
         @(negedge i_clock);
         if (o_valid && i_ready) break;
         if (t > 300) begin
            $display("FAIL done_timeout: o_valid && i_ready never seen, required 1");
            $fatal(1);
         end
      end
      @(posedge i_clock);
      #1;
      l_en = 0;
   endtask

   task automatic lit(input logic [31:0] res, input logic [4:0] rd, input logic wen, input logic exc, input logic [3:0] mc,
                      input logic [31:0] bus, input logic [3:0] strb);
      l_en = 1; l_res = res; l_rd = rd; l_wen = wen; l_exc = exc; l_mc = mc; l_bus = bus; l_strb = strb;
   endtask

   logic [2:0] rts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   logic [3:0] masks [3] = '{4'b0001, 4'b0011, 4'b1111};
   int k, g;
   logic rr, ww;

   initial begin
      repeat (3) @(posedge i_clock);
      #1 i_reset = 1;
      rdy_fix = 0;
      lit(32'h1234, 5'd5, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
      req(0, 0, 4'h0, 3'h0, 32'h0, 32'h0, 32'h1234, 5'd5, 1, 32'h8000_0100);
      repeat (3) @(posedge i_clock);
      #1 rdy_fix = 1;
      wait_done();
      use_rd = 1; kr_data = 32'h80FF_FFFF; kr_resp = 2'b00; wt_ar = 0; wt_r = 0;
      lit(32'hFFFF_FF80, 5'd1, 1'b1, 1'b0, 4'h0, 32'h8000_0000, 4'h0);
      req(1, 0, 4'h0, 3'b000, 32'h8000_0003, 32'h0, 32'h0, 5'd1, 1, 32'h8000_0104);
      wait_done();
      lit(32'h0000_0080, 5'd2, 1'b1, 1'b0, 4'h0, 32'h8000_0000, 4'h0);
      req(1, 0, 4'h0, 3'b100, 32'h8000_0003, 32'h0, 32'h0, 5'd2, 1, 32'h8000_0108);
      wait_done();
      wt_aw = 2; wt_w = 0;
      lit(32'h55, 5'd0, 1'b0, 1'b0, 4'h0, 32'hBEEF_0000, 4'b1100);
      req(0, 1, 4'b0011, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h55, 5'd0, 0, 32'h8000_010C);
      wait_done();
      wt_aw = -1; wt_w = -1; kr_resp = 2'b10;
      lit(32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 4'd5, 32'h8000_0010, 4'h0);
      kr_data = 32'hDEAD_BEEF;
      req(1, 0, 4'h0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 5'd3, 1, 32'h8000_0110);
      wait_done();
      kr_resp = 2'b00;
      lit(32'h77, 5'd4, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
      req(0, 0, 4'h0, 3'h0, 32'h0, 32'h0, 32'h77, 5'd4, 1, 32'h8000_0114);
      wait_done();
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
      lit(32'h99, 5'd6, 1'b0, 1'b1, 4'd6, 32'h0, 4'h0);
      req(0, 1, 4'b1111, 3'b010, 32'h8000_0001, 32'h1234_5678, 32'h99, 5'd6, 1, 32'h8000_0118);
      wait_done();
`endif
      wt_ar = -1; wt_r = 6; use_rd = 0;
      req(1, 0, 4'h0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 5'd7, 1, 32'h8000_011C);
      for (int t = 0; ; t++) begin
         @(negedge i_clock);
         if (m_rready) break;
         if (t > 50) begin
            $display("FAIL rd_d_timeout: m_rready never seen, required 1");
            $fatal(1);
         end
      end
      @(posedge i_clock);
      #1 i_reset = 0;
      @(posedge i_clock);
      #1 i_reset = 1;
      wt_r = -1; wt_ar = -1; wt_r = -1; rdy_rand = 1;
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 9);
         rr = k < 4 || k == 9;
         ww = (k >= 4 && k < 8) || k == 9;
         req(rr, ww, masks[$urandom_range(0, 2)], rts[$urandom_range(0, 4)], 32'h8000_0000 | ($urandom & 32'hFFFF),
             $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge i_clock);
            #1;
         end
      end
      for (int t = 0; ; t++) begin
         @(negedge i_clock);
         if (o_ready && !o_valid) break;
         if (t > 300) begin
            $display("FAIL drain_timeout: LSU never returned idle, required idle");
            $fatal(1);
         end
      end
      repeat (2) @(negedge i_clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_24110006_lsu.md
Name: ysyx_24110006_lsu

Overview:
Load/store unit sitting downstream of the execute stage. It consumes the execute stage's registered memory request (address, write data, write mask, read type) over a valid/ready handshake and issues it on an AXI4-Lite master port. It aligns and sign/zero-extends load data, then hands the writeback result to the WBU over a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

Parameters:
ADDR_W, 32, bus/request address width
DATA_W, 32, bus data width (fixed 32; other values unsupported)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-low reset (asserted when 0)
i_valid  in  1  request valid from EXU
o_ready  out  1  LSU can accept a request
i_mem_ren  in  1  load
i_mem_wen  in  1  store
i_mem_wmask  in  4  unshifted store mask: 0001 sb, 0011 sh, 1111 sw
i_mem_read_t  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
i_mem_addr  in  32  byte address
i_mem_wdata  in  32  unshifted store data
i_result  in  32  ALU/CSR result for non-load instructions
i_reg_rd  in  5  destination register
i_reg_wen  in  1  register write enable
i_pc  in  32  instruction PC
o_valid  out  1  result valid to WBU
i_ready  in  1  WBU accepts
o_result  out  32  load data or passthrough result
o_reg_rd  out  5  registered i_reg_rd
o_reg_wen  out  1  registered i_reg_wen, forced 0 on exception
o_pc  out  32  registered i_pc
o_exception  out  1  access fault (or misalign, see feature)
o_mcause  out  4  5 load access fault, 7 store access fault, 4/6 misaligned
m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  AXI read address
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  AXI read data
m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  AXI write address
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  AXI write data
m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response

Behaviour:
- Reset (i_reset==0 at posedge): state IDLE; o_valid, o_exception, all m_*valid, m_rready, m_bready = 0; o_ready = 1; o_mcause = 0. Data registers are don't-care. Reset mid-transaction abandons the bus transfer; the interconnect is reset concurrently.
- Accept: request latched when i_valid && o_ready. o_ready = (state==IDLE). DONE also accepts when i_ready, giving back-to-back passthrough.
- FSM states: IDLE, RD_A, RD_D, WR, WR_B, DONE.
- IDLE, accept: load -> RD_A; store -> WR; neither -> DONE with o_result = i_result. Exactly one path is taken per request. ren && wen together is illegal; load wins.
- RD_A: m_arvalid = 1, araddr = {addr[31:2],2'b00}. On m_arready -> RD_D.
- RD_D: m_rready = 1. On m_rvalid, latch the extended result and rresp!=0 as exception (mcause 5) -> DONE.
- Load extract: d = rdata >> (addr[1:0]*8). lb/lbu use d[7:0]; lh/lhu use d[15:0]; lw uses d. Sign-extend for lb/lh, zero-extend for lbu/lhu.
- WR: awvalid and wvalid asserted together, awaddr word-aligned, wdata = wdata_in << (addr[1:0]*8), wstrb = wmask << addr[1:0] (truncated to 4 bits).
  - Each channel drops its valid after its own handshake (handshakes may occur in either order or the same cycle).
  - When both are done -> WR_B.
- WR_B: m_bready = 1. On m_bvalid -> DONE; bresp!=0 sets exception, mcause 7. Store o_result = i_result.
- DONE: o_valid = 1 and held stable until i_ready. Then go to IDLE, or straight to the next request if i_valid is accepted in the same cycle.
- When o_exception = 1, o_reg_wen = 0. The exception flag clears on the next accept.
- Latency: passthrough 1 cycle. Load at least 3 cycles (accept -> RD_A -> RD_D -> DONE). Store at least 3 cycles.

Optional Feature:
YSYX_LSU_MISALIGN_CHECK_EN:
- Defined: in IDLE, a load or store with a misaligned address (half: addr[0]; word: addr[1:0]!=0) issues no bus transfer. It goes directly to DONE with o_exception = 1, o_mcause = 4 (load) or 6 (store), o_reg_wen = 0.
- Undefined: no check is made. Lane shifting proceeds and bytes beyond lane 3 are silently dropped.

Decomposition:
- Shared package/header (alongside alu_config.v): FSM state encodings, read-type funct3 codes, mcause constants (4, 5, 6, 7), AXI resp OKAY = 2'b00.
- Sub-module ysyx_24110006_lsu_align: combinational store shift/strobe generation plus load extract/extend. Top holds the FSM and registers.

Test Plan:
- Passthrough: valid with ren = wen = 0, result = 0x1234, rd = 5 -> o_valid the next cycle with o_result = 0x1234, o_reg_rd = 5. Hold i_ready = 0 for 3 cycles -> outputs stay stable.
- lb at addr 0x8000_0003, rdata = 0x80FF_FFFF, zero-wait slave -> araddr 0x8000_0000, o_result = 0xFFFF_FF80. lbu on the same data -> 0x0000_0080.
- sh at addr 0x8000_0002, wdata = 0x0000_BEEF, awready delayed 2 cycles, wready immediate -> m_wdata 0xBEEF_0000, m_wstrb 1100, exactly one aw and one w handshake, o_reg_wen = 0 passed.
- lw with rresp = 2'b10 -> o_exception = 1, o_mcause = 5, o_reg_wen = 0. The next accepted request clears the exception.
- Reset (i_reset = 0) during RD_D -> next cycle state IDLE, o_ready = 1, m_rready = 0, o_valid = 0.
- With YSYX_LSU_MISALIGN_CHECK_EN: sw at 0x8000_0001 -> no awvalid/wvalid ever asserted, o_exception = 1, o_mcause = 6.
